// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: round-robin sharing of one DDR write engine between NUM_CH
// write-address controllers, with a stretched per-channel done level.
module ddr_wr_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_WIDTH   = 30,
  parameter int WR_NUM_WIDTH = 28,
  parameter int DONE_HOLD    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                req_valid,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_CH*WR_NUM_WIDTH-1:0]   req_num,
  output logic [NUM_CH-1:0]                req_done,
  output logic [NUM_CH-1:0]                req_overrun,
  output logic                             ddr_wr_valid,
  input  logic                             ddr_wr_ready,
  output logic [ADDR_WIDTH-1:0]            ddr_wr_addr,
  output logic [WR_NUM_WIDTH-1:0]          ddr_wr_num,
  input  logic                             ddr_wr_done,
  output logic [$clog2(NUM_CH)-1:0]        grant_id,
  output logic                             busy
);
  localparam int IW = $clog2(NUM_CH);
  localparam int CW = $clog2(DONE_HOLD);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;
  state_e                  state_q;
  logic [NUM_CH-1:0]       vld_q, pend_q, pend_d, ovr_q, done_q, rise, clr;
  logic [ADDR_WIDTH-1:0]   addr_q [NUM_CH];
  logic [WR_NUM_WIDTH-1:0] num_q [NUM_CH];
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [WR_NUM_WIDTH-1:0] wnum_q;
  logic [IW-1:0]           rr_q, sel, idx, grant_q;
  logic [CW-1:0]           cnt_q;
  logic                    found, valid_q, busy_q;
  // Scan from the highest offset down so the channel nearest rr wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_q) + i) % NUM_CH);
      if (pend_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
  assign rise   = req_valid & ~vld_q;
  assign clr    = (state_q == IDLE && found) ? NUM_CH'(1) << sel : '0;
  assign pend_d = rise | (pend_q & ~clr);
  assign req_done     = done_q;
  assign req_overrun  = ovr_q;
  assign ddr_wr_valid = valid_q;
  assign ddr_wr_addr  = waddr_q;
  assign ddr_wr_num   = wnum_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vld_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      done_q  <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      wnum_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        addr_q[k] <= '0;
        num_q[k]  <= '0;
      end
    end else begin
      vld_q  <= req_valid;
      pend_q <= pend_d;
      ovr_q  <= ovr_q | (rise & pend_q & ~clr);
      for (int k = 0; k < NUM_CH; k++) begin
        if (rise[k]) begin
          addr_q[k] <= req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
          num_q[k]  <= req_num[k*WR_NUM_WIDTH +: WR_NUM_WIDTH];
        end
      end
      case (state_q)
        IDLE: if (found) begin
          grant_q <= sel;
          waddr_q <= addr_q[sel];
          wnum_q  <= num_q[sel];
          rr_q    <= (sel == IW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: if (ddr_wr_ready) begin
          valid_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: if (ddr_wr_done) begin
          cnt_q   <= CW'(DONE_HOLD - 1);
          done_q  <= NUM_CH'(1) << grant_q;
          state_q <= HOLD;
        end
        HOLD: if (cnt_q == '0) begin
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
